qsys_switch_debounce_ctrl: RTL and testbench



---
 rtl/qsys_switch_pkg.sv | 23 ++
 rtl/qsys_switch_debounce_ctrl_bit.sv | 55 +++++
 rtl/qsys_switch_debounce_ctrl.sv | 151 +++++++++++++++
 tb/tb_qsys_switch_debounce_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/qsys_switch_pkg.sv
// Purpose: shared constants and types for the slide-switch debounce controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package qsys_switch_pkg;

    // Avalon-MM register word addresses
    localparam logic [1:0] ADDR_STATE = 2'd0;
    localparam logic [1:0] ADDR_RAW   = 2'd1;
    localparam logic [1:0] ADDR_MASK  = 2'd2;
    localparam logic [1:0] ADDR_EDGE  = 2'd3;

    // Edge kinds that set a capture bit
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Controller state: SEED loads the debounced value once, RUN debounces forever
    typedef enum logic {
        SEED = 1'b0,
        RUN  = 1'b1
    } dbnc_state_e;

endpackage

// File: rtl/qsys_switch_debounce_ctrl_bit.sv
// Purpose: one switch bit's stability counter and debounced flop.
// Latency: debounced updates on the tick where STABLE_TICKS consecutive disagreeing samples complete.
// Backpressure: none; advances only on tick.
module switch_debounce_bit #(
    parameter int STABLE_TICKS = 10
) (
    input  logic clk,
    input  logic reset_n,
    input  logic tick,
    input  logic seed,
    input  logic sync_in,
    output logic debounced,
    output logic toggle
);

    localparam int CW = $clog2(STABLE_TICKS + 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          deb_q, deb_d;

    // Seed on the first tick, then count consecutive disagreeing ticks; counter saturates by clearing on toggle
    always_comb begin
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        toggle = 1'b0;
        if (tick) begin
            if (seed) begin
                deb_d = sync_in;
                cnt_d = '0;
            end else if (sync_in == deb_q) begin
                cnt_d = '0;
            end else if (cnt_q == CW'(STABLE_TICKS - 1)) begin
                deb_d  = ~deb_q;
                cnt_d  = '0;
                toggle = 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // State registers; reset discards any partial count
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign debounced = deb_q;

endmodule

// File: rtl/qsys_switch_debounce_ctrl.sv
// Purpose: Avalon-MM switch bank controller: sync, prescale, debounce, edge capture, IRQ (edge/IRQ logic under QSYS_SWITCH_EDGE_IRQ_EN).
// Latency: readdata one cycle after address; debounced 2 + TICK_DIV*STABLE_TICKS cycles worst case; irq one cycle after edge_cap.
// Backpressure: none; slave accepts every access, no waitrequest.
module qsys_switch_debounce_ctrl
    import qsys_switch_pkg::*;
#(
    parameter int WIDTH        = 6,
    parameter int TICK_DIV     = 50000,
    parameter int STABLE_TICKS = 10,
    parameter int EDGE_TYPE    = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int PW = $clog2(TICK_DIV);

    logic [WIDTH-1:0] sync1_q, sync1_d;
    logic [WIDTH-1:0] sync2_q, sync2_d;
    logic [PW-1:0]    presc_q, presc_d;
    dbnc_state_e      state_q, state_d;
    logic [31:0]      readdata_q, readdata_d;

    logic             tick;
    logic             seed;
    logic             wr_en;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] toggle;
    logic [WIDTH-1:0] mask_view;
    logic [WIDTH-1:0] edge_view;

    assign tick  = (presc_q == PW'(TICK_DIV - 1));
    assign seed  = (state_q == SEED);
    assign wr_en = chipselect & ~write_n;

    // Synchroniser shift, prescaler wrap and one-shot SEED->RUN transition
    always_comb begin
        sync1_d = in_port;
        sync2_d = sync1_q;
        presc_d = tick ? '0 : presc_q + 1'b1;
        state_d = state_q;
        if (state_q == SEED && tick) begin
            state_d = RUN;
        end
    end

    // Register read mux; unused upper bits read as zero
    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_STATE: readdata_d[WIDTH-1:0] = debounced;
            ADDR_RAW:   readdata_d[WIDTH-1:0] = sync2_q;
            ADDR_MASK:  readdata_d[WIDTH-1:0] = mask_view;
            default:    readdata_d[WIDTH-1:0] = edge_view;
        endcase
    end

    // Synchroniser, prescaler, controller state and read data registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            presc_q    <= '0;
            state_q    <= SEED;
            readdata_q <= '0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            presc_q    <= presc_d;
            state_q    <= state_d;
            readdata_q <= readdata_d;
        end
    end

    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
        switch_debounce_bit #(
            .STABLE_TICKS(STABLE_TICKS)
        ) u_bit (
            .clk      (clk),
            .reset_n  (reset_n),
            .tick     (tick),
            .seed     (seed),
            .sync_in  (sync2_q[gi]),
            .debounced(debounced[gi]),
            .toggle   (toggle[gi])
        );
    end

`ifdef QSYS_SWITCH_EDGE_IRQ_EN
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] edge_q, edge_d;
    logic [WIDTH-1:0] edge_set;
    logic [WIDTH-1:0] edge_clr;
    logic             irq_q, irq_d;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    // Select which debounced transitions count as edges; debounced still holds the pre-toggle value here
    always_comb begin
        edge_set = toggle;
        if (EDGE_TYPE == EDGE_RISE) begin
            edge_set = toggle & ~debounced;
        end else if (EDGE_TYPE == EDGE_FALL) begin
            edge_set = toggle & debounced;
        end
    end

    // Mask write, sticky capture with write-1-to-clear (a same-cycle set wins), IRQ from registered state
    always_comb begin
        edge_clr = (wr_en && address == ADDR_EDGE) ? writedata[WIDTH-1:0] : '0;
        mask_d   = (wr_en && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
        edge_d   = (edge_q & ~edge_clr) | edge_set;
        irq_d    = |(edge_q & mask_q);
    end

    // Edge-capture, mask and interrupt registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask_q <= '0;
            edge_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            edge_q <= edge_d;
            irq_q  <= irq_d;
        end
    end

    assign mask_view = mask_q;
    assign edge_view = edge_q;
    assign irq       = irq_q;
`else
    logic unused_edge_path;

    assign unused_edge_path = ^{writedata, wr_en, toggle};
    assign mask_view        = '0;
    assign edge_view        = '0;
    assign irq              = 1'b0;
`endif

    assign readdata = readdata_q;

endmodule

// File: tb/tb_qsys_switch_debounce_ctrl.sv
`timescale 1ns/1ps
module tb_qsys_switch_debounce_ctrl;

    localparam int W    = 6;
    localparam int TDIV = 4;
    localparam int ST   = 3;

`ifdef QSYS_SWITCH_EDGE_IRQ_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [1:0]   address = 2'd0;
    logic         chipselect = 1'b0;
    logic         write_n = 1'b1;
    logic [31:0]  writedata = 32'd0;
    logic [W-1:0] in_port = '0;
    logic [31:0]  readdata;
    logic         irq;

    always #5 clk = ~clk;

    qsys_switch_debounce_ctrl #(
        .WIDTH(W), .TICK_DIV(TDIV), .STABLE_TICKS(ST), .EDGE_TYPE(2)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata), .irq(irq)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int v, input int lo, input int hi);
        n_cmp++;
        if (v < lo || v > hi) begin
            n_err++;
            $display("FAIL %s: got %0d cycles, expected %0d..%0d (t=%0t)", name, v, lo, hi, $time);
        end
    endtask

    // Behavioural reference: raw samples delayed two cycles, a global tick every TDIV cycles,
    // and per bit the number of consecutive ticks its sample has disagreed with the debounced value.
    logic [W-1:0] m_s1, m_s2, m_deb, m_mask, m_edge;
    int           m_cyc;
    bit           m_seeded;
    int           m_run [W];
    logic [31:0]  m_rd;
    logic         m_irq;

    always @(posedge clk) begin
        logic [W-1:0] set_v;
        logic [W-1:0] nd;
        logic [W-1:0] clr;
        bit           wr;
        if (!reset_n) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_mask = '0; m_edge = '0;
            m_cyc = 0; m_seeded = 1'b0; m_rd = '0; m_irq = 1'b0;
            for (int i = 0; i < W; i++) m_run[i] = 0;
        end else begin
            set_v = '0;
            nd    = m_deb;
            if (m_cyc == TDIV - 1) begin
                if (!m_seeded) begin
                    nd = m_s2;
                    m_seeded = 1'b1;
                end else begin
                    for (int i = 0; i < W; i++) begin
                        if (m_s2[i] != m_deb[i]) begin
                            m_run[i] = m_run[i] + 1;
                            if (m_run[i] == ST) begin
                                nd[i]    = ~m_deb[i];
                                set_v[i] = 1'b1;
                                m_run[i] = 0;
                            end
                        end else begin
                            m_run[i] = 0;
                        end
                    end
                end
            end
            wr = chipselect && !write_n;
            case (address)
                2'd0:    m_rd = 32'(m_deb);
                2'd1:    m_rd = 32'(m_s2);
                2'd2:    m_rd = 32'(m_mask);
                default: m_rd = 32'(m_edge);
            endcase
            m_irq  = |(m_edge & m_mask);
            clr    = (wr && address == 2'd3) ? writedata[W-1:0] : '0;
            m_edge = (m_edge & ~clr) | set_v;
            if (wr && address == 2'd2) m_mask = writedata[W-1:0];
            if (!EDGE_EN) begin
                m_edge = '0;
                m_mask = '0;
            end
            m_deb = nd;
            m_s2  = m_s1;
            m_s1  = in_port;
            m_cyc = (m_cyc + 1) % TDIV;
        end
    end

    // Continuous cycle-by-cycle comparison against the reference
    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_readdata", readdata, m_rd);
            chk("model_irq", 32'(irq), 32'(m_irq));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [1:0]  addr;
        logic        we;
        logic [31:0] wd;
        logic [31:0] exp_en;
        logic [31:0] exp_dis;
    } vec_t;

    vec_t tbl [14];
    int   k;
    int   hold;
    bit   found;

    initial begin
        // Register-map vectors after seeding 0x2A; expected readdata is the value before that row's write
        tbl[0]  = '{2'd0, 1'b0, 32'h0,        32'h2A, 32'h2A};
        tbl[1]  = '{2'd1, 1'b0, 32'h0,        32'h2A, 32'h2A};
        tbl[2]  = '{2'd2, 1'b0, 32'h0,        32'h00, 32'h00};
        tbl[3]  = '{2'd3, 1'b0, 32'h0,        32'h00, 32'h00};
        tbl[4]  = '{2'd0, 1'b1, 32'h15,       32'h2A, 32'h2A};
        tbl[5]  = '{2'd0, 1'b0, 32'h0,        32'h2A, 32'h2A};
        tbl[6]  = '{2'd2, 1'b1, 32'hFFFFFFFF, 32'h00, 32'h00};
        tbl[7]  = '{2'd2, 1'b0, 32'h0,        32'h3F, 32'h00};
        tbl[8]  = '{2'd2, 1'b1, 32'h01,       32'h3F, 32'h00};
        tbl[9]  = '{2'd2, 1'b0, 32'h0,        32'h01, 32'h00};
        tbl[10] = '{2'd1, 1'b1, 32'h0,        32'h2A, 32'h2A};
        tbl[11] = '{2'd1, 1'b0, 32'h0,        32'h2A, 32'h2A};
        tbl[12] = '{2'd3, 1'b1, 32'h3F,       32'h00, 32'h00};
        tbl[13] = '{2'd3, 1'b0, 32'h0,        32'h00, 32'h00};

        // Seed: in_port held through reset
        in_port = 6'h2A;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        address = 2'd0;
        repeat (4) @(negedge clk);
        chk("seed_not_before_tick", readdata, 32'h0);
        @(negedge clk);
        chk("seed_state", readdata, 32'h2A);

        for (int r = 0; r < 14; r++) begin
            address    = tbl[r].addr;
            chipselect = 1'b1;
            write_n    = !tbl[r].we;
            writedata  = tbl[r].wd;
            @(negedge clk);
            chk($sformatf("table_row%0d", r), readdata, EDGE_EN ? tbl[r].exp_en : tbl[r].exp_dis);
            chk($sformatf("table_irq%0d", r), 32'(irq), 32'h0);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;

        // Clean stable fall on bit 5: latency window
        address    = 2'd0;
        in_port[5] = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (readdata[5] !== 1'b0 && k < 40);
        chk_range("stable_change_latency", k, 2 + TDIV * (ST - 1) + 1 + 1, 2 + TDIV * ST + 1);

        // Bouncing bit 0, then final rise
        in_port[0] = 1'b1; repeat (3) @(negedge clk);
        in_port[0] = 1'b0; repeat (3) @(negedge clk);
        in_port[0] = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (readdata[0] !== 1'b1 && k < 40);
        chk_range("bounce_final_latency", k, 1, 2 + TDIV * ST + 1);
        chk("irq_on_masked_rise", 32'(irq), 32'(EDGE_EN));
        address = 2'd3;
        @(negedge clk);
        chk("edge_cap_after_rise", readdata, EDGE_EN ? 32'h21 : 32'h0);

        // Write-1-to-clear; irq drops one cycle after edge_cap
        chipselect = 1'b1; write_n = 1'b0; writedata = 32'h21;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        chk("irq_lags_clear", 32'(irq), 32'(EDGE_EN));
        @(negedge clk);
        chk("edge_cap_cleared", readdata, 32'h0);
        chk("irq_after_clear", 32'(irq), 32'h0);

        // Collision: W1C of bit 0 on the exact edge bit 0 toggles back to 0
        in_port[0] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (m_cyc == TDIV - 1 && m_run[0] == ST - 1 && m_s2[0] !== m_deb[0]) found = 1'b1;
        end
        chk("collision_setup_reached", 32'(found), 32'h1);
        chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h01;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
        @(negedge clk);
        chk("collision_set_wins", readdata, EDGE_EN ? 32'h01 : 32'h0);
        address = 2'd0;
        @(negedge clk);
        chk("collision_bit_toggled", 32'(readdata[0]), 32'h0);

        // Reset while bit 3 is two ticks into a count
        in_port[3] = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk);
            if (m_run[3] == 2) found = 1'b1;
        end
        chk("midcount_setup_reached", 32'(found), 32'h1);
        reset_n = 1'b0;
        address = 2'd2;
        @(negedge clk);
        chk("midreset_readdata", readdata, 32'h0);
        chk("midreset_irq", 32'(irq), 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_reset_mask", readdata, 32'h0);
        address = 2'd3;
        @(negedge clk);
        chk("post_reset_edge", readdata, 32'h0);
        address = 2'd0;
        @(negedge clk);
        chk("post_reset_deb", readdata, 32'h0);
        repeat (2) @(negedge clk);
        chk("reseed_state", readdata, 32'h02);
        address = 2'd3;
        @(negedge clk);
        chk("reseed_no_edge", readdata, 32'h0);
        chk("reseed_irq", 32'(irq), 32'h0);

        // Randomised traffic checked by the reference each cycle
        hold = 0;
        for (int c = 0; c < 1500; c++) begin
            if (hold == 0) begin
                in_port = W'($urandom);
                hold    = $urandom_range(1, 30);
            end else begin
                hold--;
            end
            address    = 2'($urandom);
            chipselect = 1'($urandom);
            write_n    = ($urandom_range(0, 5) != 0);
            writedata  = $urandom;
            @(negedge clk);
        end
        chipselect = 1'b0;
        write_n    = 1'b1;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
